freepdk45_sram_1w1r_param: RTL

- Parametrised, single-clock 1-write/1-read synchronous SRAM behavioural model.
- Successor to the fixed-geometry 1w1r macro models, with generalised width, depth and write-mask granularity.
- Adds a selectable read latency, a read-valid strobe, a defined read/write collision policy, out-of-range detection and a synchronous reset of the output path.
- Sits in place of a generated macro for RTL simulation and for FPGA prototyping of the datapath buffers.

---
 rtl/freepdk45_sram_1w1r_param.sv | 101 ++++++++++
 1 files changed

// File: rtl/freepdk45_sram_1w1r_param.sv
// freepdk45_sram_1w1r_param: parametrised 1-write/1-read synchronous SRAM model with lane write masks,
// 1- or 2-cycle read latency, same-address collision policy, out-of-range strobe and output-path reset.
module freepdk45_sram_1w1r_param #(
    parameter int DATA_WIDTH = 56,
    parameter int WRITE_SIZE = 14,
    localparam int NUM_WMASKS = DATA_WIDTH / WRITE_SIZE,
    parameter int ADDR_WIDTH = 7,
    parameter int DEPTH = 1 << ADDR_WIDTH,
    parameter int READ_LATENCY = 1,
    parameter int RW_MODE = 0,
    parameter int VERBOSE = 0
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  csb0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic                  rvalid1,
    output logic                  collision1,
    output logic                  oob
);
    localparam logic [ADDR_WIDTH:0] LIM = (ADDR_WIDTH + 1)'(DEPTH);

    if (DATA_WIDTH % WRITE_SIZE != 0 || DEPTH > (1 << ADDR_WIDTH) || DEPTH < 1 ||
        (READ_LATENCY != 1 && READ_LATENCY != 2) || RW_MODE < 0 || RW_MODE > 2 ||
        VERBOSE < 0 || VERBOSE > 1) begin : g_bad_params
        $error("freepdk45_sram_1w1r_param: illegal parameter combination");
    end

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] w_bmask, w_old, w_merged, w_rdata;
    logic                  w_wr_in, w_rd_in, w_wr_ok, w_rd_ok, w_coll;
    logic [DATA_WIDTH-1:0] r_d1;
    logic                  r_v1, r_c1, r_oob;

    for (genvar i = 0; i < NUM_WMASKS; i++) begin : g_bmask
        assign w_bmask[i*WRITE_SIZE +: WRITE_SIZE] = {WRITE_SIZE{wmask0[i]}};
    end

    always_comb begin
        w_wr_in  = {1'b0, addr0} < LIM;
        w_rd_in  = {1'b0, addr1} < LIM;
        w_wr_ok  = !csb0 && w_wr_in;
        w_rd_ok  = !csb1 && w_rd_in;
        w_old    = w_rd_in ? r_mem[addr1] : '0;
        // an all-zero mask changes nothing, so it cannot collide
        w_coll   = w_wr_ok && w_rd_ok && addr0 == addr1 && |wmask0;
        w_merged = (din0 & w_bmask) | (w_old & ~w_bmask);
        w_rdata  = !w_rd_in ? '0 :
                   (w_coll && RW_MODE == 1) ? w_merged :
                   (w_coll && RW_MODE == 2) ? {DATA_WIDTH{1'bx}} : w_old;
    end

    always_ff @(posedge clk0)
        if (!rst0 && w_wr_ok)
            for (int i = 0; i < NUM_WMASKS; i++)
                if (wmask0[i]) r_mem[addr0][i*WRITE_SIZE +: WRITE_SIZE] <= din0[i*WRITE_SIZE +: WRITE_SIZE];

    always_ff @(posedge clk0) begin
        if (rst0) begin
            r_v1  <= 1'b0;
            r_c1  <= 1'b0;
            r_d1  <= '0;
            r_oob <= 1'b0;
        end else begin
            r_v1  <= !csb1;
            r_c1  <= w_coll;
            r_oob <= (!csb0 && !w_wr_in) || (!csb1 && !w_rd_in);
            if (!csb1) r_d1 <= w_rdata;
        end
    end

    assign oob = r_oob;

    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] r_d2;
        logic                  r_v2, r_c2;
        always_ff @(posedge clk0) begin
            if (rst0) begin
                r_v2 <= 1'b0;
                r_c2 <= 1'b0;
                r_d2 <= '0;
            end else begin
                r_v2 <= r_v1;
                r_c2 <= r_c1;
                if (r_v1) r_d2 <= r_d1;
            end
        end
        assign dout1      = r_d2;
        assign rvalid1    = r_v2;
        assign collision1 = r_c2;
    end else begin : g_lat1
        assign dout1      = r_d1;
        assign rvalid1    = r_v1;
        assign collision1 = r_c1;
    end
endmodule
